// File: rtl/detect_rr_scheduler_if.sv
// Symbol-stream bundle between the producers and the shared detector.
// The producer side drives requests, symbols and clears. The scheduler side
// returns grants, hit pulses, match levels, hit counters and busy.
interface detect_rr_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]       req;
    logic [2*N_CH-1:0]     num_flat;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       grant;
    logic [N_CH-1:0]       hit;
    logic [N_CH-1:0]       match;
    logic [CNT_W*N_CH-1:0] hit_cnt_flat;
    logic                  busy;

    modport master (
        output req, num_flat, clr,
        input  grant, hit, match, hit_cnt_flat, busy
    );

    modport slave (
        input  req, num_flat, clr,
        output grant, hit, match, hit_cnt_flat, busy
    );
endinterface

// File: rtl/detect_rr_scheduler.sv
// One 4-state symbol-sequence detector shared round-robin across N_CH streams.
// Each channel keeps its own saved context, hit pulse and saturating hit count.
module detect_rr_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    detect_rr_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } ctx_t;

    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  grant_next;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] ptr_reg;

    // A channel being cleared this cycle cannot be served, so its symbol waits.
    assign eligible = bus.req & ~bus.clr;
    assign bus.busy = |eligible;
    assign bus.grant = grant_next;

    // Round-robin pick: first eligible channel scanning from ptr upward, wrapping.
    always_comb begin
        grant_next = '0;
        gidx       = '0;
        if (!reset) begin
            for (int k = 0; k < N_CH; k++) begin
                if (grant_next == '0 && eligible[(int'(ptr_reg) + k) % N_CH]) begin
                    grant_next[(int'(ptr_reg) + k) % N_CH] = 1'b1;
                    gidx = PTR_W'((int'(ptr_reg) + k) % N_CH);
                end
            end
        end
    end

    // Pointer moves just past the served channel; it holds when nothing is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (grant_next != '0) begin
            ptr_reg <= (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            ctx_t             ctx_reg;
            ctx_t             ctx_next;
            logic             hit_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [1:0]       sym;

            assign sym = bus.num_flat[2*gi +: 2];

            // Detector transition for this channel's pending symbol; symbol 0 holds.
            always_comb begin
                ctx_next = ctx_reg;
                case (ctx_reg)
                    S0: if (sym == 2'd1) ctx_next = S1;
                    S1: if (sym == 2'd2) ctx_next = S2;
                        else if (sym == 2'd3) ctx_next = S0;
                    S2: if (sym == 2'd1) ctx_next = S1;
                        else if (sym == 2'd3) ctx_next = S3;
                    S3: if (sym == 2'd1) ctx_next = S1;
                        else if (sym == 2'd2) ctx_next = S0;
                    default: ctx_next = S0;
                endcase
            end

            // Context, hit pulse and counter advance only when this channel is served.
            always_ff @(posedge clk) begin
                if (reset || bus.clr[gi]) begin
                    ctx_reg <= S0;
                    hit_reg <= 1'b0;
                    cnt_reg <= '0;
                end else if (grant_next[gi]) begin
                    ctx_reg <= ctx_next;
                    hit_reg <= (ctx_next == S3);
                    if (ctx_next == S3 && cnt_reg != {CNT_W{1'b1}}) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    hit_reg <= 1'b0;
                end
            end

            assign bus.hit[gi]   = hit_reg;
            assign bus.match[gi] = (ctx_reg == S3);
            assign bus.hit_cnt_flat[CNT_W*gi +: CNT_W] = cnt_reg;
        end
    endgenerate
endmodule

// File: tb/tb_detect_rr_scheduler.sv
// Directed bench for detect_rr_scheduler. A second instance with 2-bit
// counters sees the same stimulus to exercise counter saturation.
module tb_detect_rr_scheduler;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    detect_rr_scheduler_if #(.N_CH(4), .CNT_W(8)) bus ();
    detect_rr_scheduler_if #(.N_CH(4), .CNT_W(2)) bus_s ();

    assign bus_s.req      = bus.req;
    assign bus_s.num_flat = bus.num_flat;
    assign bus_s.clr      = bus.clr;

    detect_rr_scheduler #(.N_CH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    detect_rr_scheduler #(.N_CH(4), .CNT_W(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sym(input int ch, input logic [1:0] v);
        bus.num_flat[2*ch +: 2] = v;
    endtask

    // Present one symbol on channel ch alone, check the grant, consume it.
    task automatic send(input int ch, input logic [1:0] v, input string tag);
        logic [3:0] exp_g;
        exp_g = 4'b0001 << ch;
        bus.req = exp_g;
        set_sym(ch, v);
        #1;
        check({tag, " grant"}, 32'(bus.grant), 32'(exp_g));
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = '0;
        bus.num_flat = '0;
        bus.clr      = '0;
        tick();
        tick();

        // Reset state; grant forced low even with requests present
        bus.req = 4'b1111;
        #1;
        check("rst grant", 32'(bus.grant), 32'h0);
        check("rst busy", 32'(bus.busy), 32'h1);
        check("rst hit", 32'(bus.hit), 32'h0);
        check("rst match", 32'(bus.match), 32'h0);
        check("rst cnt", bus.hit_cnt_flat, 32'h0);
        bus.req = '0;
        reset = 1'b0;

        // Single channel 0: 1,2,3 -> one hit
        send(0, 2'd1, "c0 s1");
        check("c0 s1 hit", 32'(bus.hit), 32'h0);
        send(0, 2'd2, "c0 s2");
        check("c0 s2 hit", 32'(bus.hit), 32'h0);
        send(0, 2'd3, "c0 s3");
        check("c0 s3 hit", 32'(bus.hit), 32'h1);
        check("c0 s3 match", 32'(bus.match), 32'h1);
        check("c0 s3 cnt", 32'(bus.hit_cnt_flat[7:0]), 32'd1);
        bus.req = '0;
        tick();
        check("c0 idle hit", 32'(bus.hit), 32'h0);
        check("c0 idle match", 32'(bus.match), 32'h1);

        // Stay in S3 on 0 and 3, leave on 2
        send(0, 2'd0, "stay0");
        check("stay0 hit", 32'(bus.hit), 32'h1);
        check("stay0 cnt", 32'(bus.hit_cnt_flat[7:0]), 32'd2);
        send(0, 2'd3, "stay3");
        check("stay3 hit", 32'(bus.hit), 32'h1);
        check("stay3 cnt", 32'(bus.hit_cnt_flat[7:0]), 32'd3);
        send(0, 2'd2, "leave");
        check("leave hit", 32'(bus.hit), 32'h0);
        check("leave match", 32'(bus.match), 32'h0);
        check("leave cnt", 32'(bus.hit_cnt_flat[7:0]), 32'd3);

        // Two more hits: 8-bit counter reaches 5, 2-bit counter holds at 3
        send(0, 2'd1, "sat a");
        send(0, 2'd2, "sat b");
        send(0, 2'd3, "sat c");
        send(0, 2'd0, "sat d");
        check("sat hit", 32'(bus.hit), 32'h1);
        check("sat cnt8", 32'(bus.hit_cnt_flat[7:0]), 32'd5);
        check("sat cnt2", 32'(bus_s.hit_cnt_flat[1:0]), 32'd3);
        bus.req = '0;

        // Fairness from ptr=0, everybody requesting symbol 1
        do_reset();
        check("fair rst cnt", bus.hit_cnt_flat, 32'h0);
        bus.req = 4'b1111;
        bus.num_flat = 8'b01_01_01_01;
        begin
            logic [3:0] seq [5];
            seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 5; i++) begin
                #1;
                check($sformatf("fair g%0d", i), 32'(bus.grant), 32'(seq[i]));
                tick();
                check($sformatf("fair m%0d", i), 32'(bus.match), 32'h0);
            end
        end
        // ch0 was in S1 -> 2 makes S2, 3 makes S3; ch1 in S1 -> 3 back to S0
        send(0, 2'd2, "fair c0 2");
        send(0, 2'd3, "fair c0 3");
        check("fair c0 hit", 32'(bus.hit), 32'h1);
        send(1, 2'd3, "fair c1 3");
        check("fair c1 hit", 32'(bus.hit), 32'h0);
        check("fair match", 32'(bus.match), 32'h1);
        bus.req = '0;

        // Interleave ch1: 1,2,3 and ch2: 1,3
        do_reset();
        bus.num_flat = '0;
        bus.req = 4'b0110;
        set_sym(1, 2'd1);
        set_sym(2, 2'd1);
        #1; check("il A grant", 32'(bus.grant), 32'h2); tick();
        set_sym(1, 2'd2);
        #1; check("il B grant", 32'(bus.grant), 32'h4); tick();
        set_sym(2, 2'd3);
        #1; check("il C grant", 32'(bus.grant), 32'h2); tick();
        set_sym(1, 2'd3);
        #1; check("il D grant", 32'(bus.grant), 32'h4); tick();
        check("il D hit", 32'(bus.hit), 32'h0);
        bus.req = 4'b0010;
        #1; check("il E grant", 32'(bus.grant), 32'h2); tick();
        check("il E hit", 32'(bus.hit), 32'h2);
        check("il match", 32'(bus.match), 32'h2);
        check("il cnt1", 32'(bus.hit_cnt_flat[15:8]), 32'd1);
        check("il cnt2", 32'(bus.hit_cnt_flat[23:16]), 32'd0);
        bus.req = '0;

        // Clear masks grant while another channel is served
        do_reset();
        bus.num_flat = '0;
        send(0, 2'd1, "clr p1");
        send(0, 2'd2, "clr p2");
        send(0, 2'd3, "clr p3");
        check("clr pre match", 32'(bus.match), 32'h1);
        send(3, 2'd0, "clr wrap");
        bus.req = 4'b0011;
        bus.clr = 4'b0001;
        set_sym(0, 2'd1);
        set_sym(1, 2'd1);
        #1;
        check("clr grant", 32'(bus.grant), 32'h2);
        check("clr busy", 32'(bus.busy), 32'h1);
        tick();
        check("clr match", 32'(bus.match), 32'h0);
        check("clr cnt0", 32'(bus.hit_cnt_flat[7:0]), 32'd0);
        bus.clr = '0;
        #1;
        check("clr next grant", 32'(bus.grant), 32'h1);
        tick();
        check("clr next hit", 32'(bus.hit), 32'h0);

        // Reset asserted mid-stream with requests present
        bus.req = 4'b1111;
        reset = 1'b1;
        #1;
        check("mid rst grant", 32'(bus.grant), 32'h0);
        tick();
        check("mid rst hit", 32'(bus.hit), 32'h0);
        check("mid rst match", 32'(bus.match), 32'h0);
        check("mid rst cnt", bus.hit_cnt_flat, 32'h0);
        reset = 1'b0;
        bus.req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/detect_rr_scheduler.md
Name: detect_rr_scheduler

Overview:
Time-multiplexes one 4-state symbol-sequence detector across N_CH independent symbol streams.
- Each channel keeps its own saved detector state (context).
- A round-robin arbiter grants at most one requesting channel per cycle.
- The granted channel's symbol is applied to that channel's context, and per-channel hit pulses, match levels and saturating hit counters are reported.
- Sits between the symbol producers and the result/status logic.

Parameters:
N_CH, 4, number of channels (legal 2..8)
CNT_W, 8, width of each per-channel hit counter

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req  input  N_CH  per-channel request; channel i holds req[i] and its num field stable until granted
num_flat  input  2*N_CH  channel i symbol in bits [2i+1:2i]
clr  input  N_CH  per-channel context/counter clear, sampled on posedge
grant  output  N_CH  one-hot, combinational; symbol of channel i consumed at posedge when grant[i]=1
hit  output  N_CH  registered, one-cycle pulse
match  output  N_CH  level: channel context == S3
hit_cnt_flat  output  CNT_W*N_CH  channel i count in bits [CNT_W*(i+1)-1:CNT_W*i]
busy  output  1  combinational OR of (req & ~clr)

Behaviour:
- Context encoding per channel: S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.
- Transitions on a consumed symbol n (any (state, n) pair not listed holds state; n=0 always holds):
  - S0: n=1 -> S1.
  - S1: n=2 -> S2; n=3 -> S0.
  - S2: n=1 -> S1; n=3 -> S3.
  - S3: n=1 -> S1; n=2 -> S0.
- Reset (reset=1 at posedge):
  - All contexts S0, rr pointer 0, hit 0, all counters 0, so match=0.
  - grant forced to 0 while reset=1; no symbol consumed.
- Eligibility: eligible = req & ~clr.
- Arbitration:
  - grant = first eligible channel scanning ptr, ptr+1, ..., wrapping modulo N_CH. All-zero if none eligible.
  - Grant is same-cycle combinational; there is no bubble between back-to-back grants.
- Pointer update: on any grant to channel g, ptr <= (g+1) mod N_CH. Without a grant, ptr holds.
- Consume on channel g:
  - ctx[g] <= next(ctx[g], n_g).
  - hit[g] <= (next == S3), so a symbol 3 arriving in S2 gives a pulse.
  - Remaining in S3 on n=0 or n=3 also pulses.
  - Latency: symbol accepted at edge k -> hit visible and match updated after edge k; counter updated at the same edge.
- Counter: hit_cnt[g] increments by 1 on each consume with next == S3. It saturates at 2^CNT_W-1 (no wrap).
- hit for all non-granted channels is 0 each cycle.
- Clear: clr[i]=1 at posedge -> ctx[i]=S0, hit_cnt[i]=0, hit[i]=0. clr[i] masks grant[i] that cycle, so a pending symbol stays pending.
- Simultaneous clr on channel i and grant to channel j≠i: both take effect independently.
- reset has priority over clr and all grants.
- Reset mid-stream: all contexts discarded; the requester must re-present after reset deasserts. Un-granted requests are never lost, only delayed.
- Fairness: with all channels requesting continuously, each channel is granted exactly once per N_CH cycles.

Test Plan:
- Reset then single channel 0: req[0]=1 with symbols 1,2,3 on three consecutive grants -> grant[0]=1 each cycle; hit[0]=1 only after the third edge; match[0]=1; hit_cnt[0]=1.
- All 4 channels req=1 continuously from ptr=0 -> grant sequence 0001,0010,0100,1000,0001. Each channel's context advances only on its own grant.
- Interleave: ch1 sends 1,2,3 while ch2 sends 1,3 -> ch1 hits (cnt=1); ch2 ends in S0, match[2]=0, no cross-channel corruption.
- Stay in S3: ch0 reaches S3, then symbols 0,3 -> hit[0] pulses twice more, cnt=3. Then symbol 2 -> match[0]=0, no hit.
- Saturation with CNT_W=2: five S3-producing consumes -> hit_cnt=3 and holds.
- clr[0] and req[0] asserted together, ptr=0, req[1]=1 -> grant=0010, ch0 ctx=S0 and cnt=0. Next cycle with clr[0]=0 -> grant=0001. Reset asserted mid-sequence -> grant=0, all outputs zero after the edge.
